// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
// Holds the operand-select codes, the register-address width and the pipeline slot record.
package fwd_hazard_unit_pkg;

    localparam int REG_W = 4;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             wr_en;
        logic             is_load;
    } stage_t;

    localparam stage_t BUBBLE = '0;

endpackage

// File: rtl/fwd_sel_logic.sv
// Priority compare for one EX operand: the MEM/EX result beats the MEM/WB result, and r0 never forwards.
// A load still in MEM has no data yet, so it is skipped in favour of WB.
module fwd_sel_logic
    import fwd_hazard_unit_pkg::*;
(
    input  logic             ex_valid_i,
    input  logic [REG_W-1:0] src_i,
    input  logic             mem_valid_i,
    input  logic             mem_wr_en_i,
    input  logic             mem_is_load_i,
    input  logic [REG_W-1:0] mem_rd_i,
    input  logic             wb_valid_i,
    input  logic             wb_wr_en_i,
    input  logic [REG_W-1:0] wb_rd_i,
    output logic [1:0]       sel_o
);

    logic mem_hit;
    logic wb_hit;

    always_comb begin
        mem_hit = mem_valid_i && mem_wr_en_i && !mem_is_load_i &&
                  (mem_rd_i != '0) && (mem_rd_i == src_i);
        wb_hit  = wb_valid_i && wb_wr_en_i && (wb_rd_i != '0) && (wb_rd_i == src_i);
        sel_o   = FWD_RF;
        if (ex_valid_i && (src_i != '0)) begin
            if (mem_hit) begin
                sel_o = FWD_MEM;
            end else if (wb_hit) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX/MEM/WB shadow pipeline that drives the EX operand forwarding muxes
// and detects load-use hazards, inserting one bubble per hazard.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_wr_en,
    input  logic             id_is_load,
    input  logic             flush,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic             stall,
    output logic [15:0]      stall_count
);

    stage_t      ex_q, mem_q, wb_q;
    stage_t      ex_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic [REG_W-1:0] src   [2];
    logic [1:0]       sel   [2];
    logic             unused_wb;

    // Only the WB slot's destination fields matter for forwarding.
    assign unused_wb = ^{wb_q.rs1, wb_q.rs2, wb_q.is_load};

    always_comb begin
        stall = id_valid && !flush && ex_q.valid && ex_q.is_load && ex_q.wr_en &&
                (ex_q.rd != '0) && ((id_rs1 == ex_q.rd) || (id_rs2 == ex_q.rd));
    end

    always_comb begin
        ex_d = BUBBLE;
        if (id_valid && !stall && !flush) begin
            ex_d.valid   = 1'b1;
            ex_d.rs1     = id_rs1;
            ex_d.rs2     = id_rs2;
            ex_d.rd      = id_rd;
            ex_d.wr_en   = id_wr_en;
            ex_d.is_load = id_is_load;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q          <= BUBBLE;
            mem_q         <= BUBBLE;
            wb_q          <= BUBBLE;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= ex_q;
            wb_q          <= mem_q;
            stall_count_q <= stall_count_d;
        end
    end

    assign src[0] = ex_q.rs1;
    assign src[1] = ex_q.rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            fwd_sel_logic u_sel (
                .ex_valid_i    (ex_q.valid),
                .src_i         (src[gi]),
                .mem_valid_i   (mem_q.valid),
                .mem_wr_en_i   (mem_q.wr_en),
                .mem_is_load_i (mem_q.is_load),
                .mem_rd_i      (mem_q.rd),
                .wb_valid_i    (wb_q.valid),
                .wb_wr_en_i    (wb_q.wr_en),
                .wb_rd_i       (wb_q.rd),
                .sel_o         (sel[gi])
            );
        end
    endgenerate

    assign fwd_sel_a   = sel[0];
    assign fwd_sel_b   = sel[1];
    assign stall_count = stall_count_q;

endmodule
